// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Opcodes, FSM state type and NZP/sign-extension helpers shared
//               by the LC-3 execute/write-back stage. Helpers work on the
//               16-bit LC-3 word.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic logic [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        logic n;
        logic z;
        n = v[15];
        z = (v == 16'h0000);
        return {n, z, (!n && !z)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_alu.sv
`default_nettype none
// ============================================================================
// Module      : lc3_alu
// Description : Combinational LC-3 ALU (ADD/AND/NOT); other opcodes give 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_alu
    import lc3_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] sr1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] result
);

    // Carry out of the add is intentionally discarded.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sr1 + op2;
            OP_AND:  result = sr1 & op2;
            OP_NOT:  result = ~sr1;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lc3_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : lc3_exec_unit
// Description : LC-3 execute/write-back stage: IDLE->EXEC->WB sequencing,
//               ALU result register, NZP condition codes and BEN evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_exec_unit
    import lc3_pkg::*;
#(
    parameter int         WIDTH   = 16,
    parameter logic [2:0] NZP_RST = 3'b010
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [15:0]      IR,
    input  logic [WIDTH-1:0] SR1,
    input  logic [WIDTH-1:0] SR2,
    input  logic             cc_load,
    input  logic [WIDTH-1:0] cc_data,
    output logic             busy,
    output logic             done,
    output logic [2:0]       SR1_sel,
    output logic [2:0]       DR,
    output logic             LD_REG,
    output logic [WIDTH-1:0] ALU_out,
    output logic [2:0]       NZP,
    output logic             BEN
);

    state_t           state;
    logic [15:0]      ir_q;
    logic [3:0]       w_opcode;
    logic             w_is_alu;
    logic             w_is_br;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH-1:0] w_result;
    logic             w_ben;

    assign w_opcode = ir_q[15:12];
    assign w_is_alu = (w_opcode == OP_ADD) || (w_opcode == OP_AND) || (w_opcode == OP_NOT);
    assign w_is_br  = (w_opcode == OP_BR);
    assign w_op2    = ir_q[5] ? WIDTH'(sext5(ir_q[4:0])) : SR2;
    assign w_ben    = (ir_q[11] & NZP[2]) | (ir_q[10] & NZP[1]) | (ir_q[9] & NZP[0]);

    assign SR1_sel  = ir_q[8:6];
    assign DR       = ir_q[11:9];

    lc3_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (w_opcode),
        .sr1    (SR1),
        .op2    (w_op2),
        .result (w_result)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            ir_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            LD_REG  <= 1'b0;
            ALU_out <= '0;
            NZP     <= NZP_RST;
            BEN     <= 1'b0;
        end else begin
            // External CC loads are dropped on the WB exit edge so an ALU result always wins.
            if (cc_load && (state != WB)) begin
                NZP <= nzp_of(16'(cc_data));
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        ir_q  <= IR;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (w_is_alu) begin
                        ALU_out <= w_result;
                    end
                    if (w_is_br) begin
                        BEN <= w_ben;
                    end
                    done   <= 1'b1;
                    LD_REG <= w_is_alu;
                    state  <= WB;
                end
                WB: begin
                    if (w_is_alu) begin
                        NZP <= nzp_of(16'(ALU_out));
                    end
                    done   <= 1'b0;
                    LD_REG <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done   <= 1'b0;
                    LD_REG <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_exec_unit
// Description : Scoreboard bench for lc3_exec_unit with a behavioural 8x16
//               register file and directed instruction vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_exec_unit;

    logic        Clk     = 1'b0;
    logic        Reset   = 1'b0;
    logic        start   = 1'b0;
    logic        cc_load = 1'b0;
    logic [15:0] IR      = 16'h0000;
    logic [15:0] cc_data = 16'h0000;
    logic [15:0] SR1;
    logic [15:0] SR2;
    logic        busy;
    logic        done;
    logic [2:0]  SR1_sel;
    logic [2:0]  DR;
    logic        LD_REG;
    logic [15:0] ALU_out;
    logic [2:0]  NZP;
    logic        BEN;

    typedef struct {
        int          due;
        logic [2:0]  sr1_sel;
        logic [2:0]  dr;
        logic        ld;
        logic [15:0] alu;
        logic        ben;
        logic [2:0]  nzp;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [15:0] ir_tb = 16'h0000;
    logic [15:0] regs [8] = '{16'hFFFF, 16'h7FFF, 16'h00F0, 16'h0F0F,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000};

    lc3_exec_unit #(
        .WIDTH   (16),
        .NZP_RST (3'b010)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (start),
        .IR      (IR),
        .SR1     (SR1),
        .SR2     (SR2),
        .cc_load (cc_load),
        .cc_data (cc_data),
        .busy    (busy),
        .done    (done),
        .SR1_sel (SR1_sel),
        .DR      (DR),
        .LD_REG  (LD_REG),
        .ALU_out (ALU_out),
        .NZP     (NZP),
        .BEN     (BEN)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Register file: SR1 follows the DUT select, SR2 follows the issued IR[2:0].
    always @(posedge Clk) if (LD_REG) regs[DR] <= ALU_out;
    assign SR1 = regs[SR1_sel];
    assign SR2 = regs[ir_tb[2:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] s1, input logic [2:0] d, input logic ld,
                                input logic [15:0] alu, input logic ben, input logic [2:0] nzp);
        exp_t e;
        e.due = 0; e.sr1_sel = s1; e.dr = d; e.ld = ld;
        e.alu = alu; e.ben = ben; e.nzp = nzp;
        return e;
    endfunction

    // Issue one instruction and walk it through EXEC and WB.
    task automatic issue(input logic [15:0] ir, input exp_t e, input bit hold,
                         input bit ccl, input logic [15:0] ccd);
        exp_t x;
        x = e;
        @(negedge Clk);
        IR = ir; ir_tb = ir; start = 1'b1;
        x.due = cyc + 2;
        q.push_back(x);
        @(negedge Clk);
        if (!hold) start = 1'b0;
        @(negedge Clk);
        if (ccl) begin cc_load = 1'b1; cc_data = ccd; end
        @(negedge Clk);
        start = 1'b0; cc_load = 1'b0;
    endtask

    task automatic set_cc(input logic [15:0] d, input logic [2:0] exp);
        @(negedge Clk);
        cc_load = 1'b1; cc_data = d;
        @(negedge Clk);
        cc_load = 1'b0;
        chk("cc_load_idle", {29'b0, NZP}, {29'b0, exp});
    endtask

    // Monitor: pops an expectation for each done pulse, then checks NZP one cycle later.
    initial begin
        exp_t       e;
        logic       nzp_pend = 1'b0;
        logic [2:0] nzp_exp  = 3'b000;
        forever begin
            @(negedge Clk);
            if (nzp_pend) begin
                chk("nzp_after_wb", {29'b0, NZP}, {29'b0, nzp_exp});
                nzp_pend = 1'b0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL spurious_done: got done=1 expected no pending instruction (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("busy_wb",    {31'b0, busy},    32'd1);
                    chk("sr1_sel",    {29'b0, SR1_sel}, {29'b0, e.sr1_sel});
                    chk("dr",         {29'b0, DR},      {29'b0, e.dr});
                    chk("ld_reg",     {31'b0, LD_REG},  {31'b0, e.ld});
                    chk("alu_out",    {16'b0, ALU_out}, {16'b0, e.alu});
                    chk("ben",        {31'b0, BEN},     {31'b0, e.ben});
                    nzp_pend = 1'b1;
                    nzp_exp  = e.nzp;
                end
            end else if (LD_REG) begin
                n_vec++; n_bad++;
                $display("FAIL stray_ld_reg: got LD_REG=1 expected 0 outside WB (t=%0t)", $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_nzp",    {29'b0, NZP},     32'h2);
        chk("rst_alu",    {16'b0, ALU_out}, 32'h0);
        chk("rst_busy",   {31'b0, busy},    32'h0);
        chk("rst_ld_reg", {31'b0, LD_REG},  32'h0);
        chk("rst_ben",    {31'b0, BEN},     32'h0);
        chk("rst_dr_sel", {26'b0, DR, SR1_sel}, 32'h0);

        issue(16'h1261, mk(3'd1, 3'd1, 1'b1, 16'h8000, 1'b0, 3'b100), 1'b0, 1'b0, 16'h0); // ADD R1,R1,#1
        issue(16'h5683, mk(3'd2, 3'd3, 1'b1, 16'h0000, 1'b0, 3'b010), 1'b0, 1'b0, 16'h0); // AND R3,R2,R3
        issue(16'h903F, mk(3'd0, 3'd0, 1'b1, 16'h0000, 1'b0, 3'b010), 1'b0, 1'b0, 16'h0); // NOT R0,R0
        set_cc(16'h8000, 3'b100);
        issue(16'h0805, mk(3'd0, 3'd4, 1'b0, 16'h0000, 1'b1, 3'b100), 1'b0, 1'b0, 16'h0); // BRn
        issue(16'h2000, mk(3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 3'b100), 1'b0, 1'b0, 16'h0); // LD: pass-through
        set_cc(16'h0001, 3'b001);
        issue(16'h0C05, mk(3'd0, 3'd6, 1'b0, 16'h0000, 1'b0, 3'b001), 1'b0, 1'b0, 16'h0); // BRnz
        issue(16'h1AB0, mk(3'd2, 3'd5, 1'b1, 16'h00E0, 1'b0, 3'b001), 1'b0, 1'b0, 16'h0); // ADD R5,R2,#-16
        set_cc(16'h0000, 3'b010);
        issue(16'h1DE5, mk(3'd7, 3'd6, 1'b1, 16'h0005, 1'b0, 3'b001), 1'b0, 1'b1, 16'hFFFF); // cc_load on WB exit
        issue(16'h1FFF, mk(3'd7, 3'd7, 1'b1, 16'hFFFF, 1'b0, 3'b100), 1'b1, 1'b0, 16'h0); // start held

        // Abort an ADD in EXEC with reset: no write-back may follow.
        @(negedge Clk);
        IR = 16'h1261; ir_tb = IR; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("busy_exec", {31'b0, busy}, 32'd1);
        Reset = 1'b0;
        #1;
        chk("busy_async_rst", {31'b0, busy}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_nzp",    {29'b0, NZP},     32'h2);
        chk("abort_alu",    {16'b0, ALU_out}, 32'h0);
        chk("abort_ld_reg", {31'b0, LD_REG},  32'h0);
        chk("abort_r1",     {16'b0, regs[1]}, 32'h8000);

        issue(16'h947F, mk(3'd1, 3'd2, 1'b1, 16'h7FFF, 1'b0, 3'b001), 1'b0, 1'b0, 16'h0); // NOT R2,R1
        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        chk("r2_written", {16'b0, regs[2]}, 32'h7FFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
